// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: default widths,
// response-slot state encoding and the ALU control codes.
package alu_arbiter_pkg;

  localparam int ALU_BITS      = 32;
  localparam int ALU_CTRL_BITS = 5;

  localparam logic [15:0] GRANT_CNT_MAX = 16'hFFFF;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

  typedef enum logic [ALU_CTRL_BITS-1:0] {
    ALUCTRL_ADD = 5'd0,
    ALUCTRL_SUB = 5'd1,
    ALUCTRL_AND = 5'd2,
    ALUCTRL_OR  = 5'd3,
    ALUCTRL_XOR = 5'd4,
    ALUCTRL_SLL = 5'd5,
    ALUCTRL_SRL = 5'd6,
    ALUCTRL_SLT = 5'd7,
    ALUCTRL_BEQ = 5'd8,
    ALUCTRL_BNE = 5'd9
  } alu_ctrl_e;

  // Saturating increment: the grant counter sticks at its maximum.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == GRANT_CNT_MAX) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/alu_arb_pick.sv
// Two-way grant select for the ALU arbiter.
// Define ALU_ARB_RR_EN for round-robin; otherwise requester 0 has fixed priority.
module alu_arb_pick
  import alu_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  input  logic       i_free,
  output logic [1:0] o_grant,
  output logic       o_grant_idx,
  output logic       o_grant_any
);

  logic w_pref;

`ifdef ALU_ARB_RR_EN
  logic r_ptr;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (o_grant_any) begin
      r_ptr <= ~o_grant_idx;
    end
  end

  assign w_pref = r_ptr;
`else
  logic w_unused_clk_rst;

  assign w_unused_clk_rst = clk ^ rst;
  assign w_pref           = 1'b0;
`endif

  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    o_grant_any = i_free & (|i_valid);
    o_grant_idx = (i_valid == 2'b11) ? w_pref : i_valid[1];
    o_grant     = 2'b00;
    if (o_grant_any) begin
      o_grant[o_grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU and registers
// its result in a one-entry response slot. Optional macro: ALU_ARB_RR_EN.
module alu_arbiter #(
  parameter int ALU_BITS      = alu_arbiter_pkg::ALU_BITS,
  parameter int ALU_CTRL_BITS = alu_arbiter_pkg::ALU_CTRL_BITS
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [ALU_CTRL_BITS-1:0] req0_ctrl,
  input  logic [ALU_BITS-1:0]      req0_a,
  input  logic [ALU_BITS-1:0]      req0_b,

  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [ALU_CTRL_BITS-1:0] req1_ctrl,
  input  logic [ALU_BITS-1:0]      req1_a,
  input  logic [ALU_BITS-1:0]      req1_b,

  output logic [ALU_CTRL_BITS-1:0] alu_ctrl,
  output logic [ALU_BITS-1:0]      alu_rdata1,
  output logic [ALU_BITS-1:0]      alu_rdata2,
  output logic                     alu_immsrc,
  output logic                     alu_pcsrc,
  input  logic [ALU_BITS-1:0]      alu_result,
  input  logic                     alu_is_zero,

  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [ALU_BITS-1:0]      rsp_result,
  output logic                     rsp_zero,

  output logic [15:0]              grant_cnt
);

  alu_arbiter_pkg::arb_state_t r_state;
  alu_arbiter_pkg::arb_state_t w_state_nxt;

  logic                w_slot_free;
  logic [1:0]          w_grant;
  logic                w_grant_idx;
  logic                w_grant_any;
  logic                r_rsp_id;
  logic [ALU_BITS-1:0] r_rsp_result;
  logic                r_rsp_zero;
  logic [15:0]         r_grant_cnt;

  // Reset blocks grants so no requester sees ready while rst is high.
  assign w_slot_free = !rst && ((r_state == alu_arbiter_pkg::ST_EMPTY) || rsp_ready);

  alu_arb_pick u_pick (
    .clk         (clk),
    .rst         (rst),
    .i_valid     ({req1_valid, req0_valid}),
    .i_free      (w_slot_free),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_grant_any (w_grant_any)
  );

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= alu_arbiter_pkg::ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      alu_arbiter_pkg::ST_EMPTY: begin
        if (w_grant_any) begin
          w_state_nxt = alu_arbiter_pkg::ST_FULL;
        end
      end
      alu_arbiter_pkg::ST_FULL: begin
        if (rsp_ready && !w_grant_any) begin
          w_state_nxt = alu_arbiter_pkg::ST_EMPTY;
        end
      end
      default: w_state_nxt = alu_arbiter_pkg::ST_EMPTY;
    endcase
  end

  // Operand mux to the shared ALU; idle cycles present all-zero fields.
  always_comb begin
    alu_ctrl   = '0;
    alu_rdata1 = '0;
    alu_rdata2 = '0;
    if (w_grant_any) begin
      if (w_grant_idx) begin
        alu_ctrl   = req1_ctrl;
        alu_rdata1 = req1_a;
        alu_rdata2 = req1_b;
      end else begin
        alu_ctrl   = req0_ctrl;
        alu_rdata1 = req0_a;
        alu_rdata2 = req0_b;
      end
    end
  end

  assign alu_immsrc = 1'b0;
  assign alu_pcsrc  = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else if (w_grant_any) begin
      r_rsp_id     <= w_grant_idx;
      r_rsp_result <= alu_result;
      r_rsp_zero   <= alu_is_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_cnt <= 16'd0;
    end else if (w_grant_any) begin
      r_grant_cnt <= alu_arbiter_pkg::sat_inc16(r_grant_cnt);
    end
  end

  assign rsp_valid  = (r_state == alu_arbiter_pkg::ST_FULL);
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign grant_cnt  = r_grant_cnt;

endmodule
